// File: rtl/vga_rx_monitor.sv
// VGA receive monitor: captures visible pixels, checks frame geometry, reports lock.
// Define VGA_RX_CHECKSUM_EN to enable the per-frame RGB checksum on frame_sum.
module vga_rx_monitor #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned V_ACTIVE = 480
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pix_en,
  input  logic [7:0]  red_vga,
  input  logic [7:0]  green_vga,
  input  logic [7:0]  blue_vga,
  input  logic        h_sync,
  input  logic        v_sync,
  input  logic        blank_n,
  input  logic        sync_n,
  output logic        pix_valid,
  output logic [23:0] pix_rgb,
  output logic [9:0]  x_pos,
  output logic [9:0]  y_pos,
  output logic        frame_done,
  output logic [31:0] frame_sum,
  output logic        width_err,
  output logic        height_err,
  output logic        locked
);

  localparam logic [9:0] H_END = 10'(H_ACTIVE);
  localparam logic [9:0] V_END = 10'(V_ACTIVE);

  typedef enum logic [1:0] {SEEK, VSYNC, FRAME} state_t;

  state_t      state_q, state_d;
  logic        hs_q, vs_q, blank_q;
  logic [9:0]  x_q, x_d, y_q, y_d;
  logic        frame_err_q, frame_err_d;
  logic        pix_valid_q, pix_valid_d;
  logic [23:0] rgb_q, rgb_d;
  logic [9:0]  xp_q, xp_d, yp_q, yp_d;
  logic        frame_done_q, frame_done_d;
  logic        werr_q, werr_d, herr_q, herr_d;
  logic        locked_q, locked_d;
  logic        vs_fall, vs_rise, blank_fall;

  logic unused_sig;
  assign unused_sig = ^{hs_q, sync_n};

  // Edges are relative to the previous pix_en sample, never to raw clk cycles.
  assign vs_fall    = vs_q & ~v_sync;
  assign vs_rise    = ~vs_q & v_sync;
  assign blank_fall = blank_q & ~blank_n;

`ifdef VGA_RX_CHECKSUM_EN
  logic [31:0] sum_q, sum_d, fsum_q, fsum_d;
`endif

  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    frame_err_d  = frame_err_q;
    pix_valid_d  = 1'b0;
    rgb_d        = rgb_q;
    xp_d         = xp_q;
    yp_d         = yp_q;
    frame_done_d = 1'b0;
    werr_d       = werr_q;
    herr_d       = herr_q;
    locked_d     = locked_q;
`ifdef VGA_RX_CHECKSUM_EN
    sum_d        = sum_q;
    fsum_d       = fsum_q;
`endif
    if (pix_en) begin
      unique case (state_q)
        SEEK: if (vs_fall) state_d = VSYNC;
        VSYNC: if (vs_rise) begin
          state_d     = FRAME;
          x_d         = '0;
          y_d         = '0;
          frame_err_d = 1'b0;
`ifdef VGA_RX_CHECKSUM_EN
          sum_d       = '0;
`endif
        end
        FRAME: begin
          if (blank_n && v_sync) begin
            pix_valid_d = 1'b1;
            rgb_d       = {red_vga, green_vga, blue_vga};
            xp_d        = x_q;
            yp_d        = y_q;
            if (x_q != '1) x_d = x_q + 10'd1;
`ifdef VGA_RX_CHECKSUM_EN
            sum_d = sum_q + 32'(red_vga) + 32'(green_vga) + 32'(blue_vga);
`endif
          end
          if (blank_fall) begin
            if (x_q != H_END) begin
              werr_d      = 1'b1;
              frame_err_d = 1'b1;
            end
            x_d = '0;
            if (y_q != '1) y_d = y_q + 10'd1;
          end
          // y_d already includes a line end on this same sample.
          if (vs_fall) begin
            if (y_d != V_END) begin
              herr_d      = 1'b1;
              frame_err_d = 1'b1;
            end
            frame_done_d = 1'b1;
            locked_d     = ~frame_err_d;
            state_d      = VSYNC;
`ifdef VGA_RX_CHECKSUM_EN
            fsum_d       = sum_d;
`endif
          end
        end
        default: state_d = SEEK;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= SEEK;
      hs_q         <= 1'b0;
      vs_q         <= 1'b0;
      blank_q      <= 1'b0;
      x_q          <= '0;
      y_q          <= '0;
      frame_err_q  <= 1'b0;
      pix_valid_q  <= 1'b0;
      rgb_q        <= '0;
      xp_q         <= '0;
      yp_q         <= '0;
      frame_done_q <= 1'b0;
      werr_q       <= 1'b0;
      herr_q       <= 1'b0;
      locked_q     <= 1'b0;
    end else begin
      if (pix_en) begin
        hs_q    <= h_sync;
        vs_q    <= v_sync;
        blank_q <= blank_n;
      end
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      frame_err_q  <= frame_err_d;
      pix_valid_q  <= pix_valid_d;
      rgb_q        <= rgb_d;
      xp_q         <= xp_d;
      yp_q         <= yp_d;
      frame_done_q <= frame_done_d;
      werr_q       <= werr_d;
      herr_q       <= herr_d;
      locked_q     <= locked_d;
    end
  end

`ifdef VGA_RX_CHECKSUM_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sum_q  <= '0;
      fsum_q <= '0;
    end else begin
      sum_q  <= sum_d;
      fsum_q <= fsum_d;
    end
  end
  assign frame_sum = fsum_q;
`else
  assign frame_sum = '0;
`endif

  assign pix_valid  = pix_valid_q;
  assign pix_rgb    = rgb_q;
  assign x_pos      = xp_q;
  assign y_pos      = yp_q;
  assign frame_done = frame_done_q;
  assign width_err  = werr_q;
  assign height_err = herr_q;
  assign locked     = locked_q;

endmodule
